hack_uart_tx: RTL and testbench
===============================

HACK_UART_TX -- requirements
Module: hack_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 12500000, system clock frequency in Hz (sys_clk domain).
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..16.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  one-cycle write strobe from memory/IO bridge (CPU store to UART data address).
REQ-007 wr_data  input  16  CPU outM; bits [7:0] are the byte to send, bits [15:8] ignored.
REQ-008 clr_ovf  input  1  one-cycle strobe clearing the sticky overflow flag.
REQ-009 status  output  16  read-back word for inM mux (layout REQ-024).
REQ-010 tx  output  1  serial line, idle high, 8N1 framing.

Function
REQ-011 Bit period DIV SHALL be CLK_HZ/BAUD, integer truncation (108 at defaults); each of start, 8 data, stop bits held exactly DIV clk cycles.
REQ-012 FIFO SHALL accept wr_data[7:0] on any cycle with wr_en=1 and full=0; count increments at that edge.
REQ-013 wr_en=1 while full=1 SHALL drop the byte, leave FIFO contents/count unchanged, and set overflow=1.
REQ-014 Full is evaluated before any same-cycle pop; a write while full is dropped even if a pop occurs that cycle.
REQ-015 Simultaneous accepted write and pop SHALL leave count unchanged and preserve FIFO order.
REQ-016 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-017 State machine states: IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-018 IDLE: tx=1; if FIFO non-empty, pop head into 8-bit shift register, clear baud counter, bit index=0, go START.
REQ-019 START: tx=0 for DIV cycles, then DATA.
REQ-020 DATA: tx=shift[0] (LSB first); each DIV cycles shift right, bit index+1; after bit 7 period go STOP.
REQ-021 STOP: tx=1 for DIV cycles, then IDLE.
REQ-022 Back-to-back frames: exactly one clk of IDLE (tx=1) between stop-bit end and next start bit.
REQ-023 Latency: write accepted at edge N into empty FIFO with state IDLE -> tx falls at edge N+2.
REQ-024 status = {8'b0, count[3:0], overflow, busy, full, empty}, bits [15:8] zero; combinational from registers.
REQ-025 clr_ovf=1 SHALL clear overflow next edge; if clr_ovf and a dropped write coincide, overflow=1 (set wins).
REQ-026 tx SHALL be driven from a register (no combinational glitches).

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, tx=1, count=0, pointers=0, overflow=0, baud counter=0, bit index=0; status reads 16'h0001.
REQ-028 Reset asserted mid-frame SHALL abort the frame; queued bytes are discarded; tx returns high without waiting for a clock.
REQ-029 After reset deassertion, no frame starts until a new byte is written.

Verification
REQ-030 Reset, write 16'hAB55 once -> tx low at edge N+2, then bits 1,0,1,0,1,0,1,0 (0x55 LSB first) each 108 clks, stop high 108 clks; status returns to 16'h0001.
REQ-031 Write 0x41,0x42,0x43 consecutive cycles -> three frames in order, exactly 1 idle clk between each; count reads 2 one cycle after third write while first frame is in START.
REQ-032 With tx stalled in frame, fill FIFO to 8 then write 0xFF -> full=1, overflow=1, status bits[7:4]=8; 0xFF never transmitted; clr_ovf clears bit3 only.
REQ-033 Write at same cycle IDLE pops from a full FIFO -> byte dropped, overflow set, count goes 8->7.
REQ-034 Assert reset in DATA bit 3 with 2 bytes queued -> tx=1 asynchronously, status=16'h0001, no further frames after release.
REQ-035 Simultaneous clr_ovf and dropped write -> overflow remains 1.

Source files
------------

// File: rtl/hack_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : hack_uart_tx
// Brief   : FIFO-buffered 8N1 UART transmitter with a CPU-readable status word.
// Revision: 1.0
// ============================================================================
module hack_uart_tx #(
  parameter int CLK_HZ     = 12500000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        clr_ovf,
  output logic [15:0] status,
  output logic        tx
);

  localparam int c_DIV    = CLK_HZ / BAUD;
  localparam int c_BAUD_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_DIV - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_ovf;
  state_t              r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_tx;

  state_t              w_state_nxt;
  logic [c_BAUD_W-1:0] w_baud_nxt;
  logic [2:0]          w_bit_nxt;
  logic [7:0]          w_shift_nxt;
  logic                w_tx_nxt;
  logic                w_pop;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic                w_busy;
  logic                w_baud_done;
  logic [3:0]          w_count4;
  logic                w_unused_hi;

  assign w_full      = (r_count == c_FULL_CNT);
  assign w_empty     = (r_count == '0);
  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  assign w_push      = wr_en && !w_full;
  assign w_busy      = (r_state != S_IDLE);
  assign w_baud_done = (r_baud == c_BAUD_LAST);
  assign w_count4    = 4'(r_count);
  assign w_unused_hi = ^wr_data[15:8];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (wr_en && w_full) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // tx follows the current state one clock later, keeping every bit exactly DIV wide.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign status = {8'h00, w_count4, r_ovf, w_busy, w_full, w_empty};
  assign tx     = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_hack_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_hack_uart_tx
// Brief   : Scoreboard bench for hack_uart_tx against a frame-level timing model.
// Revision: 1.0
// ============================================================================
module tb_hack_uart_tx;

  localparam int CLK_HZ = 12500000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 8;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        wr_en   = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        clr_ovf = 1'b0;
  logic [15:0] status;
  logic        tx;

  hack_uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .clr_ovf(clr_ovf),
    .status (status),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  bit         m_ovf        = 1'b0;
  int         m_busy_until = 0;
  int         m_last_pop   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // A popped byte owns the line for FRAME cycles; the next pop needs one idle edge after.
  function automatic logic [15:0] m_status(input int e);
    int n;
    n = m_q.size();
    return {8'h00, 4'(n), m_ovf, (e < m_busy_until - 1), (n == DEPTH), (n == 0)};
  endfunction

  task automatic model_step(input int e, input bit we, input logic [15:0] d, input bit clr);
    bit         pop;
    bit         drop;
    logic [7:0] b;
    pop  = (e >= m_busy_until) && (m_q.size() != 0);
    drop = we && (m_q.size() == DEPTH);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pop) begin
      b = m_q.pop_front();
      exp_q.push_back('{data: b, start: e + 1});
      m_busy_until = e + FRAME + 1;
      m_last_pop   = e;
    end
    if (we && !drop) m_q.push_back(d[7:0]);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_ovf        = 1'b0;
    m_busy_until = 0;
  endtask

  task automatic step(input bit we, input logic [15:0] d, input bit clr);
    wr_en   = we;
    wr_data = d;
    clr_ovf = clr;
    model_step(cyc + 1, we, d, clr);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    check("status", {16'h0, status}, {16'h0, m_status(cyc)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((m_q.size() != 0 || cyc < m_busy_until) && g < (DEPTH + 2) * FRAME) begin
      step(1'b0, 16'h0000, 1'b0);
      g++;
    end
  endtask

  // Serial monitor: decodes each frame on tx and checks it against the scoreboard.
  initial begin : monitor
    exp_t e;
    bit   ok;
    bit   aborted;
    logic exp_bit;
    int   start_c;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      start_c = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", start_c);
        repeat (FRAME - 1) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      check("frame_start", start_c, e.start);
      ok      = 1'b1;
      aborted = 1'b0;
      for (int b = 0; b < 10; b++) begin
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
        for (int k = 0; k < DIV; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== exp_bit) ok = 1'b0;
        end
        if (aborted) break;
      end
      if (!aborted) begin
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL frame_bits: byte %h started cycle %0d has wrong tx waveform", e.data, start_c);
        end
      end
    end
  end

  initial begin : driver
    int r;
    int g;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_status", {16'h0, status}, 32'h0001);
    reset = 1'b0;

    // Single frame of 0x55, upper byte ignored.
    step(1'b1, 16'hAB55, 1'b0);
    idle(FRAME + 5);

    // Three back-to-back frames.
    step(1'b1, 16'h0041, 1'b0);
    step(1'b1, 16'h0042, 1'b0);
    step(1'b1, 16'h0043, 1'b0);
    idle(3 * FRAME + 10);

    // Fill FIFO behind an active frame, then overflow scenarios.
    step(1'b1, 16'h12A0, 1'b0);
    idle(3);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h5AB0 + 16'(i), 1'b0);
    step(1'b1, 16'h00FF, 1'b0);
    idle(2);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h00FF, 1'b1);
    g = 0;
    while (cyc + 1 < m_busy_until && g < FRAME + 5) begin
      step(1'b0, 16'h0000, 1'b0);
      g++;
    end
    step(1'b1, 16'h00FF, 1'b0);
    drain();

    // Randomized traffic with occasional overflow clears.
    for (int i = 0; i < 12000; i++) begin
      r = $urandom_range(0, 999);
      step(r < 4, 16'($urandom), r == 999);
    end
    drain();

    // Reset during data bit 3 with two bytes still queued.
    step(1'b1, 16'h00C3, 1'b0);
    step(1'b1, 16'h003C, 1'b0);
    step(1'b1, 16'h0099, 1'b0);
    g = 0;
    while (cyc < m_last_pop + 4 * DIV + DIV / 2 && g < FRAME) begin
      step(1'b0, 16'h0000, 1'b0);
      g++;
    end
    check("pre_reset_tx", {31'h0, tx}, {31'h0, ~m_q[0][0] | 1'b1} & 32'h0 | {31'h0, tx_expected_bit3()});
    #1 reset = 1'b1;
    #1;
    check("async_reset_tx", {31'h0, tx}, 32'h1);
    check("async_reset_status", {16'h0, status}, 32'h0001);
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("held_reset_status", {16'h0, status}, 32'h0001);
    end
    reset = 1'b0;
    idle(12 * DIV);

    idle(5);
    check("leftover_frames", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bit 3 of 0xC3 is 0: the line must be low while the reset strikes.
  function automatic logic tx_expected_bit3();
    logic [7:0] v;
    v = 8'hC3;
    return v[3];
  endfunction

endmodule
`default_nettype wire
